// File: rtl/turtle_pkg.sv
`default_nettype none
// ============================================================
// turtle_pkg : shared datapath widths and ALU opcode encoding
// Rev 1.0
// ============================================================
package turtle_pkg;

   localparam int DATA_W = 16;
   localparam int REG_AW = 3;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_NOT = 3'd4,
      ALU_XOR = 3'd5,
      ALU_ROL = 3'd6,
      ALU_ROR = 3'd7
   } alu_op_t;

endpackage
`default_nettype wire

// File: rtl/alu_exec_stage_alu.sv
`default_nettype none
// ============================================================
// alu_exec_stage_alu : combinational ALU with carry/zero outputs
// Rev 1.0
// ============================================================
module alu_exec_stage_alu
   import turtle_pkg::*;
#(
   parameter int DATA_W = turtle_pkg::DATA_W
) (
   input  alu_op_t           op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result,
   output logic              carry,
   output logic              zero
);

   logic [DATA_W:0] sum;

   assign sum = {1'b0, a} + {1'b0, b};

   always_comb begin
      result = '0;
      carry  = 1'b0;
      case (op)
         ALU_ADD: begin
            result = sum[DATA_W-1:0];
            carry  = sum[DATA_W];
         end
         ALU_SUB: begin
            result = a - b;
            carry  = (b > a);
         end
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_NOT: result = ~a;
         ALU_XOR: result = a ^ b;
         // Rotates are single-bit; the bit rotated out lands in carry.
         ALU_ROL: begin
            result = {a[DATA_W-2:0], a[DATA_W-1]};
            carry  = a[DATA_W-1];
         end
         ALU_ROR: begin
            result = {a[0], a[DATA_W-1:1]};
            carry  = a[0];
         end
         default: begin
            result = '0;
            carry  = 1'b0;
         end
      endcase
   end

   assign zero = (result == '0);

endmodule
`default_nettype wire

// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================
// alu_exec_stage : execute stage, one-cycle ALU with result forwarding
// Rev 1.0
// ============================================================
module alu_exec_stage
   import turtle_pkg::*;
#(
   parameter int DATA_W = turtle_pkg::DATA_W,
   parameter int REG_AW = turtle_pkg::REG_AW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_op,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic              in_a_from_reg,
   input  logic              in_b_from_reg,
   input  logic [REG_AW-1:0] in_a_addr,
   input  logic [REG_AW-1:0] in_b_addr,
   input  logic [REG_AW-1:0] in_dest,
   input  logic              in_wr_en,
   input  logic              in_set_flags,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [REG_AW-1:0] out_dest,
   output logic              out_wr_en,
   output logic              flag_c,
   output logic              flag_z
);

   logic              valid_q,  valid_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic [REG_AW-1:0] dest_q,   dest_d;
   logic              wr_en_q,  wr_en_d;
   logic              c_q,      c_d;
   logic              z_q,      z_d;

   logic              accept;
   logic              fwd_hit;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic [DATA_W-1:0] alu_result;
   logic              alu_carry;
   logic              alu_zero;

   assign in_ready = rst_n & (~valid_q | out_ready);
   assign accept   = in_valid & in_ready & ~flush;

   // The held result is the newest value of its register even while stalled.
   assign fwd_hit = valid_q & wr_en_q;
   assign op_a    = (fwd_hit && in_a_from_reg && (in_a_addr == dest_q)) ? result_q : in_a;
   assign op_b    = (fwd_hit && in_b_from_reg && (in_b_addr == dest_q)) ? result_q : in_b;

   alu_exec_stage_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .op     (alu_op_t'(in_op)),
      .a      (op_a),
      .b      (op_b),
      .result (alu_result),
      .carry  (alu_carry),
      .zero   (alu_zero)
   );

   always_comb begin
      valid_d  = valid_q;
      result_d = result_q;
      dest_d   = dest_q;
      wr_en_d  = wr_en_q;
      c_d      = c_q;
      z_d      = z_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d  = 1'b1;
         result_d = alu_result;
         dest_d   = in_dest;
         wr_en_d  = in_wr_en;
         if (in_set_flags) begin
            c_d = alu_carry;
            z_d = alu_zero;
         end
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         result_q <= '0;
         dest_q   <= '0;
         wr_en_q  <= 1'b0;
         c_q      <= 1'b0;
         z_q      <= 1'b0;
      end else begin
         valid_q  <= valid_d;
         result_q <= result_d;
         dest_q   <= dest_d;
         wr_en_q  <= wr_en_d;
         c_q      <= c_d;
         z_q      <= z_d;
      end
   end

   assign out_valid  = valid_q;
   assign out_result = result_q;
   assign out_dest   = dest_q;
   assign out_wr_en  = wr_en_q;
   assign flag_c     = c_q;
   assign flag_z     = z_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
`default_nettype none
// ============================================================
// tb_alu_exec_stage : directed self-checking bench for alu_exec_stage
// Rev 1.0
// ============================================================
module tb_alu_exec_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic        in_a_from_reg;
   logic        in_b_from_reg;
   logic [2:0]  in_a_addr;
   logic [2:0]  in_b_addr;
   logic [2:0]  in_dest;
   logic        in_wr_en;
   logic        in_set_flags;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_result;
   logic [2:0]  out_dest;
   logic        out_wr_en;
   logic        flag_c;
   logic        flag_z;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_exec_stage dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_op         (in_op),
      .in_a          (in_a),
      .in_b          (in_b),
      .in_a_from_reg (in_a_from_reg),
      .in_b_from_reg (in_b_from_reg),
      .in_a_addr     (in_a_addr),
      .in_b_addr     (in_b_addr),
      .in_dest       (in_dest),
      .in_wr_en      (in_wr_en),
      .in_set_flags  (in_set_flags),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_result    (out_result),
      .out_dest      (out_dest),
      .out_wr_en     (out_wr_en),
      .flag_c        (flag_c),
      .flag_z        (flag_z)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                     input logic [2:0] dest, input logic setf);
      in_valid      = 1'b1;
      in_op         = o;
      in_a          = a;
      in_b          = b;
      in_dest       = dest;
      in_wr_en      = 1'b1;
      in_set_flags  = setf;
      in_a_from_reg = 1'b0;
      in_b_from_reg = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
      in_a_addr = 3'd0; in_b_addr = 3'd0;
      op(3'd0, 16'h1111, 16'h2222, 3'd7, 1'b1);
      tick(); tick();
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_result", out_result, 0);
      check("rst_dest", out_dest, 0);
      check("rst_wr_en", out_wr_en, 0);
      check("rst_flag_c", flag_c, 0);
      check("rst_flag_z", flag_z, 0);
      rst_n = 1'b1;
      #1;
      check("rel_in_ready", in_ready, 1);

      // ADD with carry-out and zero result
      op(3'd0, 16'hFFFF, 16'h0001, 3'd3, 1'b1);
      tick();
      check("add_valid", out_valid, 1);
      check("add_result", out_result, 16'h0000);
      check("add_dest", out_dest, 3);
      check("add_wr_en", out_wr_en, 1);
      check("add_c", flag_c, 1);
      check("add_z", flag_z, 1);

      // SUB with borrow, then XOR forwarding A from r2
      op(3'd1, 16'h0005, 16'h0007, 3'd2, 1'b1);
      tick();
      check("sub_result", out_result, 16'hFFFE);
      check("sub_c", flag_c, 1);
      check("sub_z", flag_z, 0);
      op(3'd5, 16'h1234, 16'h00FF, 3'd4, 1'b0);
      in_a_from_reg = 1'b1; in_a_addr = 3'd2;
      tick();
      check("xor_fwd_result", out_result, 16'hFF01);
      check("xor_dest", out_dest, 4);
      check("xor_c_hold", flag_c, 1);
      check("xor_z_hold", flag_z, 0);

      // Backpressure: next op must wait
      out_ready = 1'b0;
      op(3'd0, 16'h0001, 16'h0001, 3'd5, 1'b1);
      #1;
      for (int i = 0; i < 3; i++) begin
         check("bp_in_ready", in_ready, 0);
         tick();
         check("bp_valid", out_valid, 1);
         check("bp_result", out_result, 16'hFF01);
         check("bp_c", flag_c, 1);
         check("bp_z", flag_z, 0);
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", in_ready, 1);
      tick();
      check("bp_acc_valid", out_valid, 1);
      check("bp_acc_result", out_result, 16'h0002);
      check("bp_acc_dest", out_dest, 5);
      check("bp_acc_c", flag_c, 0);
      check("bp_acc_z", flag_z, 0);

      // Flush kills held result and blocks the offered op
      flush = 1'b1;
      op(3'd0, 16'hFFFF, 16'h0001, 3'd1, 1'b1);
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      check("fl_valid", out_valid, 0);
      check("fl_result_hold", out_result, 16'h0002);
      check("fl_dest_hold", out_dest, 5);
      check("fl_c", flag_c, 0);
      check("fl_z", flag_z, 0);

      // Rotates and NOT
      op(3'd7, 16'h0001, 16'h0000, 3'd1, 1'b1);
      tick();
      check("ror_result", out_result, 16'h8000);
      check("ror_c", flag_c, 1);
      check("ror_z", flag_z, 0);
      op(3'd6, 16'h8000, 16'h0000, 3'd1, 1'b1);
      tick();
      check("rol_result", out_result, 16'h0001);
      check("rol_c", flag_c, 1);
      op(3'd4, 16'hFFFF, 16'h0000, 3'd6, 1'b1);
      tick();
      check("not_result", out_result, 16'h0000);
      check("not_c", flag_c, 0);
      check("not_z", flag_z, 1);

      // Forward B from r6 (held 0x0000) instead of stale 0xFFFF
      op(3'd3, 16'h00F0, 16'hFFFF, 3'd0, 1'b0);
      in_b_from_reg = 1'b1; in_b_addr = 3'd6;
      tick();
      check("or_fwd_b_result", out_result, 16'h00F0);
      check("or_c_hold", flag_c, 0);
      check("or_z_hold", flag_z, 1);

      in_valid = 1'b0;
      tick();
      check("drain_valid", out_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1);
   end

endmodule
`default_nettype wire
